rst_sequencer: RTL and testbench

Generates the per-domain active-low resets for the chip from three sources: power-on/pin reset (`rst_n_async`), a software reset request with a four-phase handshake, and a watchdog expiry pulse. Any reset event drives every output domain reset low, holds it for a fixed stretch, then releases the domains one at a time in index order with a fixed gap between releases. The block sits at the top of the clock/reset tree, between the board reset pin and every downstream domain. It also reports busy status and the cause of the most recent reset.

---
 rtl/rst_seq_pkg.sv | 21 ++
 rtl/rst_sync_cell.sv | 27 ++
 rtl/rst_sequencer.sv | 158 +++++++++++++++
 tb/tb_rst_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_IDLE    = 2'd2
  } seq_state_e;

  localparam logic [1:0] CAUSE_POR = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;
  localparam logic [1:0] CAUSE_WDT = 2'b11;

  // Counter must reach max(hold, gap) - 1; never narrower than one bit.
  function automatic int cnt_width(input int hold_cycles, input int gap_cycles);
    int m;
    m = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/rst_sync_cell.sv
// Reset synchronizer: asserts asynchronously, deasserts after SYNC_STAGES clk edges.
module rst_sync_cell #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n_async,
  output logic rst_n_sync
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n_async) begin
    if (!rst_n_async) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rst_n_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Chip reset sequencer: holds all domain resets, then releases them in index order.
//   state      | meaning
//   ST_HOLD    | all domains in reset, counting the hold stretch
//   ST_RELEASE | releasing domains 1..N-1, one per gap
//   ST_IDLE    | all domains out of reset, waiting for sw edge or watchdog
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOMAINS = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n_async,
  input  logic                   sw_rst_req,
  output logic                   sw_rst_ack,
  input  logic                   wdt_expire,
  output logic [NUM_DOMAINS-1:0] rst_n_out,
  output logic                   rst_busy,
  output logic [1:0]             rst_cause
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

  logic rst_int_n;

  seq_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] rst_n_q, rst_n_d;
  logic                   busy_q, busy_d;
  logic                   ack_q, ack_d;
  logic [1:0]             cause_q, cause_d;
  logic                   pending_q, pending_d;
  logic                   sw_prev_q, sw_prev_d;
  logic                   sw_edge;
  logic                   go_idle;

  rst_sync_cell #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rst_sync (
    .clk        (clk),
    .rst_n_async(rst_n_async),
    .rst_n_sync (rst_int_n)
  );

  assign sw_edge = sw_rst_req & ~sw_prev_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_n_d   = rst_n_q;
    busy_d    = busy_q;
    ack_d     = ack_q;
    cause_d   = cause_q;
    pending_d = pending_q;
    sw_prev_d = sw_rst_req;
    go_idle   = 1'b0;

    if (ack_q && !sw_rst_req) begin
      ack_d     = 1'b0;
      pending_d = 1'b0;
    end
    // A sw edge mid-sequence is remembered and acked at the end, never restarts.
    if (sw_edge) begin
      pending_d = 1'b1;
    end

    if (wdt_expire || (sw_edge && state_q == ST_IDLE)) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      rst_n_d = '0;
      busy_d  = 1'b1;
      cause_d = wdt_expire ? CAUSE_WDT : CAUSE_SW;
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            rst_n_d[0] = 1'b1;
            cnt_d      = '0;
            if (NUM_DOMAINS == 1) begin
              go_idle = 1'b1;
            end else begin
              state_d = ST_RELEASE;
              idx_d   = IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (cnt_q == GAP_LAST) begin
            for (int k = 0; k < NUM_DOMAINS; k++) begin
              if (idx_q == IDX_W'(k)) begin
                rst_n_d[k] = 1'b1;
              end
            end
            cnt_d = '0;
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == IDX_LAST) begin
              go_idle = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end

    if (go_idle) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      if (pending_d) begin
        ack_d = 1'b1;
      end
    end
  end

  // sw_prev resets high so a request already asserted at reset is not an edge.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q   <= ST_HOLD;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_n_q   <= '0;
      busy_q    <= 1'b1;
      ack_q     <= 1'b0;
      cause_q   <= CAUSE_POR;
      pending_q <= 1'b0;
      sw_prev_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_n_q   <= rst_n_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      cause_q   <= cause_d;
      pending_q <= pending_d;
      sw_prev_q <= sw_prev_d;
    end
  end

  assign rst_n_out  = rst_n_q;
  assign rst_busy   = busy_q;
  assign sw_rst_ack = ack_q;
  assign rst_cause  = cause_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer: default instance plus a 1/1/1 degenerate instance.
module tb_rst_sequencer;
  import rst_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_async, sw_rst_req, wdt_expire, sw_rst_ack, rst_busy;
  logic [2:0] rst_n_out;
  logic [1:0] rst_cause;

  logic       rst2_n, sw2_req, wdt2, ack2, busy2;
  logic [0:0] out2;
  logic [1:0] cause2;

  int n_cmp = 0;
  int n_err = 0;

  rst_sequencer dut (
    .clk        (clk),
    .rst_n_async(rst_n_async),
    .sw_rst_req (sw_rst_req),
    .sw_rst_ack (sw_rst_ack),
    .wdt_expire (wdt_expire),
    .rst_n_out  (rst_n_out),
    .rst_busy   (rst_busy),
    .rst_cause  (rst_cause)
  );

  rst_sequencer #(
    .NUM_DOMAINS(1),
    .HOLD_CYCLES(1),
    .GAP_CYCLES (1),
    .SYNC_STAGES(2)
  ) dut2 (
    .clk        (clk),
    .rst_n_async(rst2_n),
    .sw_rst_req (sw2_req),
    .sw_rst_ack (ack2),
    .wdt_expire (wdt2),
    .rst_n_out  (out2),
    .rst_busy   (busy2),
    .rst_cause  (cause2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] obs();
    return {rst_n_out, rst_busy, sw_rst_ack, rst_cause};
  endfunction

  function automatic logic [4:0] obs2();
    return {out2, busy2, ack2, cause2};
  endfunction

  // Domain d is released once rel >= 16 + 4*d edges after the sequence start.
  function automatic logic [2:0] exp_out(input int rel);
    logic [2:0] e;
    for (int d = 0; d < 3; d++) e[d] = (rel >= 16 + 4 * d);
    return e;
  endfunction

  task automatic test_reset();
    rst_n_async = 1'b0; rst2_n = 1'b0;
    sw_rst_req = 1'b0; wdt_expire = 1'b0; sw2_req = 1'b0; wdt2 = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (obs() !== {3'b000, 1'b1, 1'b0, CAUSE_POR}) begin
      n_err++; $display("FAIL reset_state got %b want %b", obs(), {3'b000, 1'b1, 1'b0, CAUSE_POR});
    end
    n_cmp++;
    if (obs2() !== {1'b0, 1'b1, 1'b0, CAUSE_POR}) begin
      n_err++; $display("FAIL reset_state_deg got %b want %b", obs2(), {1'b0, 1'b1, 1'b0, CAUSE_POR});
    end
  endtask

  task automatic test_por();
    logic [6:0] want;
    rst_n_async = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      want = {exp_out(k - 2), (k < 26), 1'b0, CAUSE_POR};
      n_cmp++;
      if (obs() !== want) begin
        n_err++; $display("FAIL por edge=%0d got %b want %b", k, obs(), want);
      end
    end
  endtask

  task automatic test_sw_from_idle();
    logic [6:0] want;
    sw_rst_req = 1'b1;
    tick();
    n_cmp++;
    if (obs() !== {3'b000, 1'b1, 1'b0, CAUSE_SW}) begin
      n_err++; $display("FAIL sw_start got %b want %b", obs(), {3'b000, 1'b1, 1'b0, CAUSE_SW});
    end
    for (int j = 1; j <= 26; j++) begin
      tick();
      want = {exp_out(j), (j < 24), (j >= 24), CAUSE_SW};
      n_cmp++;
      if (obs() !== want) begin
        n_err++; $display("FAIL sw_seq edge=%0d got %b want %b", j, obs(), want);
      end
    end
    for (int j = 0; j < 4; j++) begin
      tick();
      n_cmp++;
      if (obs() !== {3'b111, 1'b0, 1'b1, CAUSE_SW}) begin
        n_err++; $display("FAIL sw_held_high got %b want %b", obs(), {3'b111, 1'b0, 1'b1, CAUSE_SW});
      end
    end
    sw_rst_req = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      n_cmp++;
      if (obs() !== {3'b111, 1'b0, 1'b0, CAUSE_SW}) begin
        n_err++; $display("FAIL sw_ack_fall got %b want %b", obs(), {3'b111, 1'b0, 1'b0, CAUSE_SW});
      end
    end
  endtask

  task automatic test_wdt_restart();
    logic [6:0] want;
    wdt_expire = 1'b1; tick(); wdt_expire = 1'b0;
    n_cmp++;
    if (obs() !== {3'b000, 1'b1, 1'b0, CAUSE_WDT}) begin
      n_err++; $display("FAIL wdt_start got %b want %b", obs(), {3'b000, 1'b1, 1'b0, CAUSE_WDT});
    end
    repeat (16) tick();
    n_cmp++;
    if (obs() !== {3'b001, 1'b1, 1'b0, CAUSE_WDT}) begin
      n_err++; $display("FAIL wdt_dom0_up got %b want %b", obs(), {3'b001, 1'b1, 1'b0, CAUSE_WDT});
    end
    wdt_expire = 1'b1; tick(); wdt_expire = 1'b0;
    n_cmp++;
    if (obs() !== {3'b000, 1'b1, 1'b0, CAUSE_WDT}) begin
      n_err++; $display("FAIL wdt_restart got %b want %b", obs(), {3'b000, 1'b1, 1'b0, CAUSE_WDT});
    end
    for (int j = 1; j <= 26; j++) begin
      tick();
      want = {exp_out(j), (j < 24), 1'b0, CAUSE_WDT};
      n_cmp++;
      if (obs() !== want) begin
        n_err++; $display("FAIL wdt_seq edge=%0d got %b want %b", j, obs(), want);
      end
    end
  endtask

  task automatic test_sw_mid_seq();
    logic [6:0] want;
    wdt_expire = 1'b1; tick(); wdt_expire = 1'b0;
    repeat (5) tick();
    sw_rst_req = 1'b1;
    tick();
    n_cmp++;
    if (obs() !== {3'b000, 1'b1, 1'b0, CAUSE_WDT}) begin
      n_err++; $display("FAIL mid_sw_no_restart got %b want %b", obs(), {3'b000, 1'b1, 1'b0, CAUSE_WDT});
    end
    for (int j = 7; j <= 26; j++) begin
      tick();
      want = {exp_out(j), (j < 24), (j >= 24), CAUSE_WDT};
      n_cmp++;
      if (obs() !== want) begin
        n_err++; $display("FAIL mid_sw_seq edge=%0d got %b want %b", j, obs(), want);
      end
    end
    sw_rst_req = 1'b0; tick();
    n_cmp++;
    if (obs() !== {3'b111, 1'b0, 1'b0, CAUSE_WDT}) begin
      n_err++; $display("FAIL mid_sw_ack_fall got %b want %b", obs(), {3'b111, 1'b0, 1'b0, CAUSE_WDT});
    end
  endtask

  task automatic test_simultaneous();
    logic [6:0] want;
    sw_rst_req = 1'b1; wdt_expire = 1'b1; tick(); wdt_expire = 1'b0;
    n_cmp++;
    if (obs() !== {3'b000, 1'b1, 1'b0, CAUSE_WDT}) begin
      n_err++; $display("FAIL simul_start got %b want %b", obs(), {3'b000, 1'b1, 1'b0, CAUSE_WDT});
    end
    for (int j = 1; j <= 26; j++) begin
      tick();
      want = {exp_out(j), (j < 24), (j >= 24), CAUSE_WDT};
      n_cmp++;
      if (obs() !== want) begin
        n_err++; $display("FAIL simul_seq edge=%0d got %b want %b", j, obs(), want);
      end
    end
    sw_rst_req = 1'b0; tick();
    n_cmp++;
    if (obs() !== {3'b111, 1'b0, 1'b0, CAUSE_WDT}) begin
      n_err++; $display("FAIL simul_ack_fall got %b want %b", obs(), {3'b111, 1'b0, 1'b0, CAUSE_WDT});
    end
  endtask

  task automatic test_async_reset();
    logic [6:0] want;
    sw_rst_req = 1'b1; tick();
    repeat (18) tick();
    n_cmp++;
    if (obs() !== {3'b001, 1'b1, 1'b0, CAUSE_SW}) begin
      n_err++; $display("FAIL async_pre got %b want %b", obs(), {3'b001, 1'b1, 1'b0, CAUSE_SW});
    end
    #3 rst_n_async = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== {3'b000, 1'b1, 1'b0, CAUSE_POR}) begin
      n_err++; $display("FAIL async_assert got %b want %b", obs(), {3'b000, 1'b1, 1'b0, CAUSE_POR});
    end
    tick(); tick();
    rst_n_async = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      want = {exp_out(k - 2), (k < 26), 1'b0, CAUSE_POR};
      n_cmp++;
      if (obs() !== want) begin
        n_err++; $display("FAIL async_por edge=%0d got %b want %b", k, obs(), want);
      end
    end
    sw_rst_req = 1'b0; tick();
  endtask

  task automatic test_degenerate();
    logic [4:0] want;
    rst2_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      want = {(k >= 3), (k < 3), 1'b0, CAUSE_POR};
      n_cmp++;
      if (obs2() !== want) begin
        n_err++; $display("FAIL deg_por edge=%0d got %b want %b", k, obs2(), want);
      end
    end
    wdt2 = 1'b1; tick(); wdt2 = 1'b0;
    n_cmp++;
    if (obs2() !== {1'b0, 1'b1, 1'b0, CAUSE_WDT}) begin
      n_err++; $display("FAIL deg_wdt_start got %b want %b", obs2(), {1'b0, 1'b1, 1'b0, CAUSE_WDT});
    end
    tick();
    n_cmp++;
    if (obs2() !== {1'b1, 1'b0, 1'b0, CAUSE_WDT}) begin
      n_err++; $display("FAIL deg_wdt_done got %b want %b", obs2(), {1'b1, 1'b0, 1'b0, CAUSE_WDT});
    end
    sw2_req = 1'b1; tick();
    n_cmp++;
    if (obs2() !== {1'b0, 1'b1, 1'b0, CAUSE_SW}) begin
      n_err++; $display("FAIL deg_sw_start got %b want %b", obs2(), {1'b0, 1'b1, 1'b0, CAUSE_SW});
    end
    tick();
    n_cmp++;
    if (obs2() !== {1'b1, 1'b0, 1'b1, CAUSE_SW}) begin
      n_err++; $display("FAIL deg_sw_ack got %b want %b", obs2(), {1'b1, 1'b0, 1'b1, CAUSE_SW});
    end
    sw2_req = 1'b0; tick();
    n_cmp++;
    if (obs2() !== {1'b1, 1'b0, 1'b0, CAUSE_SW}) begin
      n_err++; $display("FAIL deg_sw_ack_fall got %b want %b", obs2(), {1'b1, 1'b0, 1'b0, CAUSE_SW});
    end
  endtask

  initial begin
    test_reset();
    test_por();
    test_sw_from_idle();
    test_wdt_restart();
    test_sw_mid_seq();
    test_simultaneous();
    test_async_reset();
    test_degenerate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
